// File: rtl/dft_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the scan-test sequencer and its helpers.
//   state_e           : 3-bit encoding of the sequencer states
//   CHAIN_LEN_DEFAULT : default number of flops in the scan chain
// -----------------------------------------------------------------------------
package dft_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_e;

endpackage : dft_pkg

// File: rtl/scan_bit_cnt.sv
// -----------------------------------------------------------------------------
// scan_bit_cnt
// Down-counter that times one full pass over the scan chain. Loading sets it
// to CHAIN_LEN-1, so a load followed by CHAIN_LEN decrement cycles lands on
// zero in the last of those cycles.
//   clk    : rising-edge clock
//   rstn   : asynchronous active-low reset (count cleared)
//   load_i : reload to CHAIN_LEN-1 (wins over dec_i)
//   dec_i  : decrement by one, holding at zero
//   zero_o : count is zero
// -----------------------------------------------------------------------------
module scan_bit_cnt
  import dft_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CHAIN_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : scan_bit_cnt

// File: rtl/scan_test_ctrl.sv
// -----------------------------------------------------------------------------
// scan_test_ctrl
// Scan-test sequencer for a single scan chain. Per test it shifts a pattern
// into the chain, pulses one functional capture, shifts the response out,
// and compares it against an expected word.
//
// Ports:
//   clk, rstn  : clock and asynchronous active-low reset (shared with chain)
//   start      : request a test; only honoured in IDLE
//   pattern    : stimulus, bit i lands in chain flop i
//   expected   : expected captured value, bit i = flop i
//   clr_cnt    : synchronous clear of err_count (beats a same-cycle increment)
//   chain_so   : serial output of the chain's last flop
//   scan_en    : chain scan enable
//   scan_in    : chain serial input (first flop)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse in the DONE state
//   pass       : last completed test matched
//   response   : last captured chain value, bit i = flop i
//   fail_mask  : response ^ expected for the last completed test
//   err_count  : saturating count of failed tests
// -----------------------------------------------------------------------------
module scan_test_ctrl
  import dft_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 clr_cnt,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response,
  output logic [CHAIN_LEN-1:0] fail_mask,
  output logic [CNT_W-1:0]     err_count
);

  state_e               state_q,      state_d;
  logic [CHAIN_LEN-1:0] pattern_sr_q, pattern_sr_d;
  logic [CHAIN_LEN-1:0] exp_q,        exp_d;
  logic [CHAIN_LEN-1:0] resp_sr_q,    resp_sr_d;
  logic [CHAIN_LEN-1:0] response_q,   response_d;
  logic [CHAIN_LEN-1:0] fail_mask_q,  fail_mask_d;
  logic                 pass_q,       pass_d;
  logic [CNT_W-1:0]     err_q,        err_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // One counter times both shift phases; it is reloaded on entry to each.
  scan_bit_cnt #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_bit_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pattern_sr_d = pattern_sr_q;
    exp_d        = exp_q;
    resp_sr_d    = resp_sr_q;
    response_d   = response_q;
    fail_mask_d  = fail_mask_q;
    pass_d       = pass_q;
    err_d        = err_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_sr_d = pattern;
          exp_d        = expected;
          cnt_load     = 1'b1;
          state_d      = S_SHIFT_IN;
        end
      end

      // MSB leaves first, so pattern[CHAIN_LEN-1] travels furthest down
      // the chain and pattern[0] ends up in flop 0.
      S_SHIFT_IN: begin
        pattern_sr_d = pattern_sr_q << 1;
        cnt_dec      = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          state_d  = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        state_d = S_SHIFT_OUT;
      end

      // The first bit out is the last flop; after CHAIN_LEN samples it has
      // moved up to the MSB, so bit i of resp_sr matches flop i.
      S_SHIFT_OUT: begin
        resp_sr_d = {resp_sr_q[CHAIN_LEN-2:0], chain_so};
        cnt_dec   = 1'b1;
        if (cnt_zero) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        response_d  = resp_sr_q;
        fail_mask_d = resp_sr_q ^ exp_q;
        pass_d      = (resp_sr_q == exp_q);
        if ((resp_sr_q != exp_q) && (err_q != '1)) begin
          err_d = err_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clr_cnt) begin
      err_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pattern_sr_q <= '0;
      exp_q        <= '0;
      resp_sr_q    <= '0;
      response_q   <= '0;
      fail_mask_q  <= '0;
      pass_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      pattern_sr_q <= pattern_sr_d;
      exp_q        <= exp_d;
      resp_sr_q    <= resp_sr_d;
      response_q   <= response_d;
      fail_mask_q  <= fail_mask_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
    end
  end

  // Moore decode from registered state only.
  assign scan_en   = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT);
  assign scan_in   = (state_q == S_SHIFT_IN) ? pattern_sr_q[CHAIN_LEN-1] : 1'b0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign response  = response_q;
  assign fail_mask = fail_mask_q;
  assign err_count = err_q;

endmodule : scan_test_ctrl
